// File: rtl/window_ctrl.sv
// ---------------------------------------------------------------------------
// window_ctrl
//
// Sequencing controller for the sliding-window front end. It owns the
// upstream pixel handshake, tracks the input row/column, and marks which
// accepted pixels complete a full kernel window (no-padding convolution).
// The pixel datapath lives outside this block; it only receives shift_o.
//
// Ports:
//   clk_i         rising-edge clock
//   reset_ni      asynchronous active-low reset
//   start_i       arms one frame (sampled only in IDLE)
//   valid_i       upstream pixel valid
//   ready_o       upstream ready (accept = valid_i && ready_o)
//   shift_o       shift enable for line buffers / window registers
//   valid_o       window registers hold a valid output window
//   ready_i       downstream ready
//   out_col_o     output column of the presented window
//   out_row_o     output row of the presented window
//   last_o        presented window is the final one of the frame
//   busy_o        controller is not IDLE
//   frame_done_o  one-cycle pulse after the final window is taken
// ---------------------------------------------------------------------------
module window_ctrl #(
  parameter int line_width_p   = 640,
  parameter int frame_height_p = 480,
  parameter int kernel_p       = 3,
  localparam int out_col_w_lp  = ((line_width_p - kernel_p + 1) > 1)
                                 ? $clog2(line_width_p - kernel_p + 1) : 1,
  localparam int out_row_w_lp  = ((frame_height_p - kernel_p + 1) > 1)
                                 ? $clog2(frame_height_p - kernel_p + 1) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    start_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    shift_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [out_col_w_lp-1:0] out_col_o,
  output logic [out_row_w_lp-1:0] out_row_o,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    frame_done_o
);

  localparam int col_w_lp = (line_width_p > 1) ? $clog2(line_width_p) : 1;
  localparam int row_w_lp = (frame_height_p > 1) ? $clog2(frame_height_p) : 1;

  localparam logic [col_w_lp-1:0] col_last_lp = col_w_lp'(line_width_p - 1);
  localparam logic [row_w_lp-1:0] row_last_lp = row_w_lp'(frame_height_p - 1);
  localparam logic [col_w_lp-1:0] col_k1_lp   = col_w_lp'(kernel_p - 1);
  localparam logic [row_w_lp-1:0] row_k1_lp   = row_w_lp'(kernel_p - 1);
  localparam logic [row_w_lp-1:0] row_k2_lp   = row_w_lp'(kernel_p - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [col_w_lp-1:0]     c_q, c_d;
  logic [row_w_lp-1:0]     r_q, r_d;
  logic                    valid_q, valid_d;
  logic [out_col_w_lp-1:0] col_q, col_d;
  logic [out_row_w_lp-1:0] row_q, row_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;

  logic accept;
  logic productive;
  logic col_last;
  logic row_last;

  // Input is only taken while the window registers are free or being
  // emptied this cycle, so an unconsumed window is never overwritten.
  assign ready_o    = ((state_q == PRIME) || (state_q == STREAM)) && (!valid_q || ready_i);
  assign shift_o    = valid_i && ready_o;
  assign accept     = shift_o;
  assign col_last   = (c_q == col_last_lp);
  assign row_last   = (r_q == row_last_lp);
  assign productive = accept && (r_q >= row_k1_lp) && (c_q >= col_k1_lp);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    valid_d = valid_q;
    col_d   = col_q;
    row_d   = row_q;
    last_d  = last_q;
    done_d  = 1'b0;

    // Raster position with explicit wrap at the terminal values.
    if (accept) begin
      if (col_last) begin
        c_d = '0;
        r_d = row_last ? '0 : r_q + row_w_lp'(1);
      end else begin
        c_d = c_q + col_w_lp'(1);
      end
    end

    // A productive accept reloads the output register even when the
    // current window is being taken in the same cycle.
    if (productive) begin
      valid_d = 1'b1;
      col_d   = out_col_w_lp'(c_q - col_k1_lp);
      row_d   = out_row_w_lp'(r_q - row_k1_lp);
      last_d  = row_last && col_last;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          c_d     = '0;
          r_d     = '0;
          state_d = PRIME;
        end
      end
      PRIME: begin
        // The row wrap that lands on row kernel_p-1 starts streaming.
        if (accept && col_last && (r_q == row_k2_lp)) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept && col_last && row_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (valid_q && ready_i && last_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      c_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      valid_q <= valid_d;
      col_q   <= col_d;
      row_q   <= row_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign valid_o      = valid_q;
  assign out_col_o    = col_q;
  assign out_row_o    = row_q;
  assign last_o       = last_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_window_ctrl
//
// Bench for window_ctrl with an 8x6 frame and a 3x3 kernel. A frame-level
// reference model (pixel index -> row/column by division) predicts every
// output each cycle; a raster counter checks the order of taken windows;
// directed scenarios pin the model with hand-computed numbers.
// ---------------------------------------------------------------------------
module tb_window_ctrl;

  localparam int LW   = 8;
  localparam int FH   = 6;
  localparam int K    = 3;
  localparam int OW   = LW - K + 1;
  localparam int OH   = FH - K + 1;
  localparam int NWIN = OW * OH;
  localparam int NPIX = LW * FH;

  logic       clk      = 1'b0;
  logic       reset_ni = 1'b0;
  logic       start_i  = 1'b0;
  logic       valid_i  = 1'b0;
  logic       ready_i  = 1'b0;
  logic       ready_o;
  logic       shift_o;
  logic       valid_o;
  logic [2:0] out_col_o;
  logic [1:0] out_row_o;
  logic       last_o;
  logic       busy_o;
  logic       frame_done_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Counters maintained by the compare process
  int win_k     = 0;
  int n_windows = 0;
  int n_frames  = 0;
  int n_accepts = 0;

  always #5 clk = ~clk;

  window_ctrl #(
    .line_width_p  (LW),
    .frame_height_p(FH),
    .kernel_p      (K)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .start_i     (start_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .shift_o     (shift_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .out_col_o   (out_col_o),
    .out_row_o   (out_row_o),
    .last_o      (last_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o)
  );

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the next rising edge.
  task automatic applyStimulus(input logic s, input logic v, input logic r);
    start_i = s;
    valid_i = v;
    ready_i = r;
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Reference model: phase 0 idle, 1 taking pixels, 2 waiting for the last
  // window to be taken. m_idx is the raster index of the next pixel.
  // -------------------------------------------------------------------------
  int   m_phase = 0;
  int   m_idx   = 0;
  int   m_row   = 0;
  int   m_col   = 0;
  logic m_valid = 1'b0;
  logic m_last  = 1'b0;
  logic m_done  = 1'b0;
  logic m_ready;
  logic mdl_acc;
  logic mdl_hs;

  assign m_ready = (m_phase == 1) && (!m_valid || ready_i);

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      m_phase = 0;
      m_idx   = 0;
      m_row   = 0;
      m_col   = 0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_done  = 1'b0;
    end else begin
      mdl_acc = valid_i && m_ready;
      mdl_hs  = m_valid && ready_i;
      m_done  = 1'b0;
      case (m_phase)
        0: begin
          if (start_i) begin
            m_phase = 1;
            m_idx   = 0;
          end
        end
        1: begin
          if (mdl_acc && (m_idx / LW) >= K - 1 && (m_idx % LW) >= K - 1) begin
            m_valid = 1'b1;
            m_row   = m_idx / LW - (K - 1);
            m_col   = m_idx % LW - (K - 1);
            m_last  = (m_idx == NPIX - 1);
          end else if (mdl_hs) begin
            m_valid = 1'b0;
          end
          if (mdl_acc) begin
            m_idx++;
            if (m_idx == NPIX) m_phase = 2;
          end
        end
        default: begin
          if (mdl_hs) begin
            m_valid = 1'b0;
            m_done  = 1'b1;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Compare process: model vs DUT every cycle, plus raster-order checking of
  // each window as it is taken downstream.
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    checkOutput("ready_o", ready_o, m_ready);
    checkOutput("shift_o", shift_o, valid_i && m_ready);
    checkOutput("valid_o", valid_o, m_valid);
    checkOutput("busy_o", busy_o, m_phase != 0);
    checkOutput("frame_done_o", frame_done_o, m_done);
    checkOutput("out_row_o", out_row_o, m_row);
    checkOutput("out_col_o", out_col_o, m_col);
    checkOutput("last_o", last_o, m_last);
    if (!reset_ni) begin
      win_k = 0;
    end else begin
      if (shift_o) n_accepts++;
      if (frame_done_o) n_frames++;
      if (valid_o && ready_i) begin
        checkOutput("raster_row", out_row_o, win_k / OW);
        checkOutput("raster_col", out_col_o, win_k % OW);
        checkOutput("raster_last", last_o, win_k == NWIN - 1);
        n_windows++;
        win_k = (win_k == NWIN - 1) ? 0 : win_k + 1;
      end
    end
  end

  // Full-rate frame with hand-computed expectations.
  task automatic runFullRate(input string tag);
    int  a0, w0, f0, vcycles, lastc;
    bit  seen;
    a0      = n_accepts;
    w0      = n_windows;
    f0      = n_frames;
    vcycles = 0;
    lastc   = 0;
    seen    = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    start_i = 1'b0;
    for (int cyc = 0; cyc < 200 && !frame_done_o; cyc++) begin
      @(posedge clk);
      #1;
      if (valid_o) begin
        vcycles++;
        if (last_o) lastc++;
        if (!seen) begin
          seen = 1'b1;
          checkOutput({tag, "_first_valid_accepts"}, n_accepts - a0, 19);
          checkOutput({tag, "_first_row"}, out_row_o, 0);
          checkOutput({tag, "_first_col"}, out_col_o, 0);
        end
      end
    end
    checkOutput({tag, "_first_valid_seen"}, seen, 1);
    checkOutput({tag, "_frame_done"}, frame_done_o, 1);
    checkOutput({tag, "_idle_at_done"}, busy_o, 0);
    checkOutput({tag, "_accepts"}, n_accepts - a0, NPIX);
    checkOutput({tag, "_windows"}, n_windows - w0, NWIN);
    checkOutput({tag, "_valid_cycles"}, vcycles, NWIN);
    checkOutput({tag, "_last_count"}, lastc, 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput({tag, "_done_pulse_once"}, n_frames - f0, 1);
    checkOutput({tag, "_done_falls"}, frame_done_o, 0);
  endtask

  initial begin
    int a0, w0, f0;

    // Reset held with live inputs: everything stays at reset values.
    reset_ni = 1'b0;
    start_i  = 1'b1;
    valid_i  = 1'b1;
    ready_i  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready_o", ready_o, 0);
    checkOutput("rst_shift_o", shift_o, 0);
    checkOutput("rst_valid_o", valid_o, 0);
    checkOutput("rst_out_row", out_row_o, 0);
    checkOutput("rst_out_col", out_col_o, 0);
    checkOutput("rst_last_o", last_o, 0);
    checkOutput("rst_busy_o", busy_o, 0);
    checkOutput("rst_frame_done", frame_done_o, 0);

    // Released without start: never ready.
    reset_ni = 1'b1;
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("idle_ready_o", ready_o, 0);
    checkOutput("idle_busy_o", busy_o, 0);

    runFullRate("full");

    // Back-pressure from the first window onward.
    w0 = n_windows;
    f0 = n_frames;
    applyStimulus(1'b1, 1'b1, 1'b0);
    start_i = 1'b0;
    for (int cyc = 0; cyc < 100 && !valid_o; cyc++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("bp_valid_seen", valid_o, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("bp_ready_o", ready_o, 0);
      checkOutput("bp_shift_o", shift_o, 0);
      checkOutput("bp_valid_o", valid_o, 1);
      checkOutput("bp_row", out_row_o, 0);
      checkOutput("bp_col", out_col_o, 0);
    end
    ready_i = 1'b1;
    for (int cyc = 0; cyc < 300 && !frame_done_o; cyc++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("bp_frame_done", frame_done_o, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("bp_windows", n_windows - w0, NWIN);
    checkOutput("bp_frames", n_frames - f0, 1);

    // Three frames of random traffic; start_i held high so each frame starts
    // right after the previous one's done cycle (where it must be ignored).
    w0 = n_windows;
    f0 = n_frames;
    start_i = 1'b1;
    for (int cyc = 0; cyc < 5000 && (n_frames - f0) < 3; cyc++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = 1'($urandom_range(0, 1));
      if ((n_frames - f0) >= 2 && busy_o) start_i = 1'b0;
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    checkOutput("rand_frames", n_frames - f0, 3);
    checkOutput("rand_windows", n_windows - w0, 3 * NWIN);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("rand_idle_after", busy_o, 0);

    // Mid-frame asynchronous reset after 30 accepts.
    f0 = n_frames;
    applyStimulus(1'b1, 1'b1, 1'b1);
    start_i = 1'b0;
    a0 = n_accepts;
    for (int cyc = 0; cyc < 100 && (n_accepts - a0) < 30; cyc++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mid_accepts", n_accepts - a0, 30);
    checkOutput("mid_valid_before", valid_o, 1);
    reset_ni = 1'b0;
    #1;
    checkOutput("mid_rst_ready_o", ready_o, 0);
    checkOutput("mid_rst_shift_o", shift_o, 0);
    checkOutput("mid_rst_valid_o", valid_o, 0);
    checkOutput("mid_rst_out_row", out_row_o, 0);
    checkOutput("mid_rst_out_col", out_col_o, 0);
    checkOutput("mid_rst_last_o", last_o, 0);
    checkOutput("mid_rst_busy_o", busy_o, 0);
    checkOutput("mid_rst_frame_done", frame_done_o, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_ni = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("mid_no_frame_done", n_frames - f0, 0);

    runFullRate("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
